tdm_demux4: RTL and testbench

//  1-to-4 time-division demultiplexer: the receive end of a 4-slot TDM link.

---
 rtl/tdm_demux4_pkg.sv | 18 +
 rtl/tdm_demux4_if.sv | 52 +++++
 rtl/tdm_demux4_dec2to4_en.sv | 24 ++
 rtl/tdm_demux4.sv | 154 +++++++++++++++
 tb/tb_tdm_demux4.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux4_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux4_pkg
// Shared definitions for the 4-slot TDM receive demultiplexer.
//   state_e   : frame-alignment state (HUNT while searching, LOCKED once aligned)
//   NUM_SLOTS : number of time slots per frame
//   SLOT_W    : width of a slot index
// ---------------------------------------------------------------------------
package tdm_demux4_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage : tdm_demux4_pkg

// File: rtl/tdm_demux4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux4_if
// Bundles the serial sample input and the parallel frame outputs of the
// TDM demultiplexer.
//   in_valid    : in / in_sync carry a sample this cycle
//   in_sync     : sample is slot 0 of a frame
//   in          : slot sample, WIDTH bits
//   out         : last complete frame, slot k at out[k*WIDTH +: WIDTH]
//   frame_valid : one-cycle pulse when out has just been updated
//   locked      : high while frame alignment is held
//   sync_err    : one-cycle pulse on a frame sync arriving mid-frame
//   slot        : slot index the next accepted sample will occupy
// Modports: master = sample source / observer, slave = the demultiplexer.
// ---------------------------------------------------------------------------
interface tdm_demux4_if
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic                   in_valid;
  logic                   in_sync;
  logic [WIDTH-1:0]       in;
  logic [NUM_SLOTS*WIDTH-1:0] out;
  logic                   frame_valid;
  logic                   locked;
  logic                   sync_err;
  logic [SLOT_W-1:0]      slot;

  modport master (
    output in_valid,
    output in_sync,
    output in,
    input  out,
    input  frame_valid,
    input  locked,
    input  sync_err,
    input  slot
  );

  modport slave (
    input  in_valid,
    input  in_sync,
    input  in,
    output out,
    output frame_valid,
    output locked,
    output sync_err,
    output slot
  );

endinterface : tdm_demux4_if

// File: rtl/tdm_demux4_dec2to4_en.sv
// ---------------------------------------------------------------------------
// dec2to4_en
// 2-to-4 one-hot write-enable decoder with a global enable.
//   slot_i : slot index to select
//   en_i   : when low, no enable is asserted
//   we_o   : one-hot write enables, bit k selects slot k
// ---------------------------------------------------------------------------
module dec2to4_en
  import tdm_demux4_pkg::*;
(
  input  logic [SLOT_W-1:0]    slot_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] we_o
);

  // One-hot select of the addressed slot, gated by the enable.
  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o = NUM_SLOTS'(1) << slot_i;
    end
  end

endmodule : dec2to4_en

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
// Receive end of a 4-slot TDM link. Captures samples in slot order 0..3 from
// one serial stream, tracks frame alignment with a HUNT/LOCKED state machine
// and presents each complete frame on four parallel lanes.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : tdm_demux4_if slave modport (sample input, frame outputs)
// Parameters:
//   WIDTH      : bits per slot sample
//   MISS_LIMIT : consecutive slot-0 samples without sync before lock is dropped
// ---------------------------------------------------------------------------
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  localparam int MISS_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

  state_e                     state_q, state_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [MISS_W-1:0]          missCnt_q, missCnt_d;
  logic [MISS_W-1:0]          missNext;
  logic [WIDTH-1:0]           shadow_q [NUM_SLOTS-1];
  logic [NUM_SLOTS*WIDTH-1:0] out_q, out_d;
  logic                       frameValid_q, frameValid_d;
  logic                       syncErr_q, syncErr_d;

  logic                       writeEn;
  logic [SLOT_W-1:0]          writeSlot;
  logic                       clearShadow;
  logic [NUM_SLOTS-1:0]       we;

  // Slot-3 write enable doubles as the frame-complete strobe, since slot 3
  // goes straight to the output instead of into a shadow register.
  dec2to4_en u_dec (
    .slot_i (writeSlot),
    .en_i   (writeEn),
    .we_o   (we)
  );

  // Alignment FSM and slot/miss bookkeeping. Every decision is taken only on
  // accepted samples; idle cycles leave everything as it was.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    missCnt_d   = missCnt_q;
    syncErr_d   = 1'b0;
    writeEn     = 1'b0;
    writeSlot   = slot_q;
    clearShadow = 1'b0;
    missNext    = missCnt_q + MISS_W'(1);

    if (bus.in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (bus.in_sync) begin
            writeEn   = 1'b1;
            writeSlot = '0;
            slot_d    = SLOT_W'(1);
            missCnt_d = '0;
            state_d   = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (slot_q == '0) begin
            if (bus.in_sync) begin
              writeEn   = 1'b1;
              slot_d    = SLOT_W'(1);
              missCnt_d = '0;
            end else if (int'(missNext) < MISS_LIMIT) begin
              // Tolerate a missing sync flag, but remember it.
              writeEn   = 1'b1;
              slot_d    = SLOT_W'(1);
              missCnt_d = missNext;
            end else begin
              clearShadow = 1'b1;
              slot_d      = '0;
              missCnt_d   = '0;
              state_d     = ST_HUNT;
            end
          end else if (bus.in_sync) begin
            // Early sync: drop the partial frame and restart at slot 0.
            syncErr_d   = 1'b1;
            clearShadow = 1'b1;
            writeEn     = 1'b1;
            writeSlot   = '0;
            slot_d      = SLOT_W'(1);
            missCnt_d   = '0;
          end else begin
            writeEn = 1'b1;
            slot_d  = slot_q + SLOT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output frame assembly: the last slot is taken directly from the input.
  always_comb begin
    out_d        = out_q;
    frameValid_d = we[NUM_SLOTS-1];
    if (we[NUM_SLOTS-1]) begin
      out_d = {bus.in, shadow_q[2], shadow_q[1], shadow_q[0]};
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      slot_q       <= '0;
      missCnt_q    <= '0;
      out_q        <= '0;
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      missCnt_q    <= missCnt_d;
      out_q        <= out_d;
      frameValid_q <= frameValid_d;
      syncErr_q    <= syncErr_d;
    end
  end

  // Shadow registers for slots 0..2. A clear and a slot-0 write can occur on
  // the same edge (early sync), so the write wins over the clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SLOTS - 1; k++) begin
      if (rst) begin
        shadow_q[k] <= '0;
      end else if (we[k]) begin
        shadow_q[k] <= bus.in;
      end else if (clearShadow) begin
        shadow_q[k] <= '0;
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.frame_valid = frameValid_q;
  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.sync_err    = syncErr_q;
  assign bus.slot        = slot_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4
// Self-checking bench for tdm_demux4 (WIDTH=4, MISS_LIMIT=2). A frame-level
// reference model (queue of captured samples) predicts every output after
// each clock edge; directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

  localparam int WIDTH      = 4;
  localparam int MISS_LIMIT = 2;

  logic clk;
  logic rst;

  tdm_demux4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux4 #(
    .WIDTH      (WIDTH),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: samples collected for the frame in progress.
  logic [WIDTH-1:0] frameQ [$];
  bit               modelLocked;
  int               modelMiss;
  logic [15:0]      expOut;
  bit               expFv;
  bit               expErr;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model reaction to one clock edge with the given inputs.
  task automatic modelStep(input bit valid, input bit sync, input logic [WIDTH-1:0] data);
    expFv  = 1'b0;
    expErr = 1'b0;
    if (!valid) return;
    if (!modelLocked) begin
      if (sync) begin
        frameQ = {data};
        modelLocked = 1'b1;
        modelMiss = 0;
      end
    end else if (frameQ.size() == 0) begin
      if (sync) begin
        frameQ.push_back(data);
        modelMiss = 0;
      end else begin
        modelMiss++;
        if (modelMiss >= MISS_LIMIT) begin
          modelLocked = 1'b0;
          modelMiss = 0;
        end else begin
          frameQ.push_back(data);
        end
      end
    end else if (sync) begin
      expErr = 1'b1;
      frameQ = {data};
      modelMiss = 0;
    end else begin
      frameQ.push_back(data);
      if (frameQ.size() == 4) begin
        expOut = {frameQ[3], frameQ[2], frameQ[1], frameQ[0]};
        expFv  = 1'b1;
        frameQ.delete();
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_out"},    32'(bus.out),         32'(expOut));
    checkOutput({tag, "_fv"},     32'(bus.frame_valid), 32'(expFv));
    checkOutput({tag, "_locked"}, 32'(bus.locked),      32'(modelLocked));
    checkOutput({tag, "_err"},    32'(bus.sync_err),    32'(expErr));
    checkOutput({tag, "_slot"},   32'(bus.slot),        32'(frameQ.size()));
  endtask

  // Drive one cycle of inputs, clock it in, update the model and compare.
  task automatic applyStimulus(input bit valid, input bit sync,
                               input logic [WIDTH-1:0] data, input string tag);
    bus.in_valid = valid;
    bus.in_sync  = sync;
    bus.in       = data;
    @(posedge clk);
    #1;
    modelStep(valid, sync, data);
    checkAll(tag);
  endtask

  task automatic applyReset(input int cycles, input string tag);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_sync  = 1'($urandom);
      bus.in       = WIDTH'($urandom);
      @(posedge clk);
      #1;
      frameQ.delete();
      modelLocked = 1'b0;
      modelMiss   = 0;
      expOut      = '0;
      expFv       = 1'b0;
      expErr      = 1'b0;
      checkAll(tag);
    end
    rst = 1'b0;
  endtask

  task automatic sendSample(input bit sync, input logic [WIDTH-1:0] data, input string tag);
    applyStimulus(1'b1, sync, data, tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'($urandom), WIDTH'($urandom), tag);
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in       = '0;
    modelLocked  = 1'b0;
    modelMiss    = 0;
    expOut       = '0;
    expFv        = 1'b0;
    expErr       = 1'b0;
    @(negedge clk);

    // 1. Reset with random inputs.
    applyReset(2, "t1_rst");
    checkOutput("t1_out_zero", 32'(bus.out), 32'h0000);

    // 2. Garbage while hunting, then a synced frame.
    sendSample(1'b0, 4'hA, "t2_a");
    sendSample(1'b0, 4'hB, "t2_b");
    sendSample(1'b1, 4'h1, "t2_s1");
    checkOutput("t2_locked_now", 32'(bus.locked), 32'd1);
    sendSample(1'b0, 4'h2, "t2_s2");
    sendSample(1'b0, 4'h3, "t2_s3");
    sendSample(1'b0, 4'h4, "t2_s4");
    checkOutput("t2_frame", 32'(bus.out), 32'h4321);
    checkOutput("t2_fv", 32'(bus.frame_valid), 32'd1);

    // 3. Frame with idle cycles between samples.
    sendSample(1'b1, 4'h5, "t3_s5");
    idleCycle("t3_i0");
    sendSample(1'b0, 4'h6, "t3_s6");
    idleCycle("t3_i1");
    idleCycle("t3_i2");
    sendSample(1'b0, 4'h7, "t3_s7");
    idleCycle("t3_i3");
    checkOutput("t3_hold", 32'(bus.out), 32'h4321);
    sendSample(1'b0, 4'h8, "t3_s8");
    checkOutput("t3_frame", 32'(bus.out), 32'h8765);
    idleCycle("t3_i4");

    // 4. Early sync mid-frame.
    sendSample(1'b1, 4'h1, "t4_s1");
    sendSample(1'b0, 4'h2, "t4_s2");
    sendSample(1'b1, 4'h9, "t4_s9");
    checkOutput("t4_syncerr", 32'(bus.sync_err), 32'd1);
    sendSample(1'b0, 4'hA, "t4_sa");
    sendSample(1'b0, 4'hB, "t4_sb");
    sendSample(1'b0, 4'hC, "t4_sc");
    checkOutput("t4_frame", 32'(bus.out), 32'hCBA9);

    // 5. Missing sync on two consecutive frame starts.
    sendSample(1'b0, 4'hD, "t5_sd");
    sendSample(1'b0, 4'h1, "t5_s1");
    sendSample(1'b0, 4'h2, "t5_s2");
    sendSample(1'b0, 4'h3, "t5_s3");
    checkOutput("t5_frame", 32'(bus.out), 32'h321D);
    sendSample(1'b0, 4'hE, "t5_se");
    checkOutput("t5_unlocked", 32'(bus.locked), 32'd0);
    checkOutput("t5_slot", 32'(bus.slot), 32'd0);

    // 6. Reset mid-frame.
    sendSample(1'b1, 4'h1, "t6_s1");
    sendSample(1'b0, 4'h2, "t6_s2");
    applyReset(1, "t6_rst");
    sendSample(1'b0, 4'h3, "t6_s3");
    sendSample(1'b0, 4'h4, "t6_s4");
    checkOutput("t6_out", 32'(bus.out), 32'h0000);
    checkOutput("t6_locked", 32'(bus.locked), 32'd0);

    // Randomized run: mostly well-formed frames with injected faults.
    for (int n = 0; n < 800; n++) begin
      bit v;
      bit s;
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1, "rnd_rst");
      end else begin
        v = ($urandom_range(0, 4) != 0);
        if (frameQ.size() == 0) s = ($urandom_range(0, 9) < 7);
        else                    s = ($urandom_range(0, 19) == 0);
        applyStimulus(v, s, WIDTH'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_tdm_demux4
